// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants, state encoding and helpers for the oversampled UART receiver
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_WAIT_HI
    } rx_state_t;

    localparam int OS_RATE     = 16;
    localparam int DEF_CLKFREQ = 48000000;
    localparam int DEF_BAUD    = 115200;

    function automatic int calc_div(input int clkfreq, input int baud);
        return clkfreq / (OS_RATE * baud);
    endfunction

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/rx_fifo.sv
// rtl/rx_fifo.sv - show-ahead synchronous FIFO with occupancy count
module rx_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO is still taken.
    assign do_push = push & (~full | do_pop);
    assign rdata   = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/rxuart_os16.sv
// rtl/rxuart_os16.sv - 16x oversampled UART receiver with majority vote, error flags and receive FIFO
import uart_pkg::*;

module rxuart_os16 #(
    parameter int CLKFREQ    = DEF_CLKFREQ,
    parameter int BAUD       = DEF_BAUD,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         uart_rx,
    input  logic                         rd,
    input  logic                         clr_err,
    output logic                         valid,
    output logic [7:0]                   data,
    output logic [$clog2(FIFO_DEPTH):0]  count,
    output logic                         frame_err,
    output logic                         overrun,
    output logic                         break_det
);

    localparam int DIV = calc_div(CLKFREQ, BAUD);
    localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

    logic            rx_meta;
    logic            rx_s;
    logic [DW-1:0]   div_cnt;
    logic            tick;
    logic [3:0]      ph;
    logic            s7;
    logic            s8;
    logic            maj;
    logic            is_dec;
    rx_state_t       state;
    rx_state_t       state_n;
    logic [7:0]      shreg;
    logic [2:0]      bit_idx;
    logic            restart;
    logic            shift_en;
    logic            push;
    logic            fe_set;
    logic            brk_set;
    logic            ovr_set;
    logic            fifo_full;
    logic            fifo_empty;

    assign tick   = (div_cnt == DIV_LAST);
    assign is_dec = tick && (ph == 4'd9);
    assign maj    = maj3(s7, s8, rx_s);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= uart_rx;
            rx_s    <= rx_meta;
        end
    end

    // Divider and phase realign to the start edge so ph 7..9 straddle each bit centre.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt <= '0;
            ph      <= '0;
            s7      <= 1'b1;
            s8      <= 1'b1;
        end else if (restart) begin
            div_cnt <= '0;
            ph      <= '0;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
            if (tick) begin
                ph <= ph + 4'd1;
                if (ph == 4'd7) s7 <= rx_s;
                if (ph == 4'd8) s8 <= rx_s;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            shreg   <= '0;
            bit_idx <= '0;
        end else begin
            state <= state_n;
            if (restart) begin
                bit_idx <= '0;
            end else if (shift_en) begin
                shreg   <= {maj, shreg[7:1]};
                bit_idx <= bit_idx + 3'd1;
            end
        end
    end

    always_comb begin
        state_n  = state;
        restart  = 1'b0;
        shift_en = 1'b0;
        push     = 1'b0;
        fe_set   = 1'b0;
        brk_set  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!rx_s) begin
                    state_n = ST_START;
                    restart = 1'b1;
                end
            end
            ST_START: begin
                if (is_dec && maj) begin
                    state_n = ST_IDLE;
                end else if (tick && ph == 4'd15) begin
                    state_n = ST_DATA;
                end
            end
            ST_DATA: begin
                if (is_dec) begin
                    shift_en = 1'b1;
                    if (bit_idx == 3'd7) state_n = ST_STOP;
                end
            end
            ST_STOP: begin
                // Leaving at mid stop bit lets the next start edge be caught early.
                if (is_dec) begin
                    if (maj) begin
                        push    = 1'b1;
                        state_n = ST_IDLE;
                    end else begin
                        fe_set  = 1'b1;
                        brk_set = (shreg == 8'h00);
                        state_n = ST_WAIT_HI;
                    end
                end
            end
            ST_WAIT_HI: begin
                if (rx_s) state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    assign ovr_set = push & fifo_full & ~rd;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            break_det <= 1'b0;
        end else begin
            frame_err <= fe_set  | (frame_err & ~clr_err);
            overrun   <= ovr_set | (overrun   & ~clr_err);
            break_det <= brk_set | (break_det & ~clr_err);
        end
    end

    rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (rd),
        .wdata (shreg),
        .rdata (data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (count)
    );

    assign valid = ~fifo_empty;

endmodule

// File: tb/tb_rxuart_os16.sv
// tb/tb_rxuart_os16.sv - randomized self-checking bench for rxuart_os16 against a frame-level model
`timescale 1ns/1ps
module tb_rxuart_os16;

    localparam int      DIV   = 4;
    localparam int      DEPTH = 16;
    localparam realtime CLK_T = 10.0;
    localparam realtime BIT_T = 16 * DIV * CLK_T;

    logic       clk = 1'b0;
    logic       reset;
    logic       uart_rx;
    logic       rd;
    logic       clr_err;
    logic       valid;
    logic [7:0] data;
    logic [4:0] count;
    logic       frame_err;
    logic       overrun;
    logic       break_det;

    int checks = 0;
    int errors = 0;

    byte unsigned q[$];
    bit m_fe, m_ov, m_brk;

    rxuart_os16 #(
        .CLKFREQ    (6400000),
        .BAUD       (100000),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .uart_rx   (uart_rx),
        .rd        (rd),
        .clr_err   (clr_err),
        .valid     (valid),
        .data      (data),
        .count     (count),
        .frame_err (frame_err),
        .overrun   (overrun),
        .break_det (break_det)
    );

    always #(CLK_T / 2) clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Push lands on cycle 618 after a negedge-aligned start edge at nominal rate (DIV=4).
    task automatic send_frame(input byte unsigned b, input bit stop, input real factor, input bit rd_at_push);
        realtime bt;
        bt = BIT_T * factor;
        if (rd_at_push) begin
            fork
                begin
                    #(618 * CLK_T);
                    rd = 1'b1;
                    #(CLK_T);
                    rd = 1'b0;
                end
            join_none
        end
        uart_rx = 1'b0;
        #(bt);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            #(bt);
        end
        uart_rx = stop;
        #(bt);
        uart_rx = 1'b1;
        if (stop) begin
            if (q.size() < DEPTH) begin
                q.push_back(b);
            end else if (rd_at_push) begin
                void'(q.pop_front());
                q.push_back(b);
            end else begin
                m_ov = 1'b1;
            end
        end else begin
            m_fe = 1'b1;
            if (b == 8'h00) m_brk = 1'b1;
        end
    endtask

    task automatic read_one(input string tag);
        @(negedge clk);
        check({tag, ".valid"}, valid, q.size() != 0);
        check({tag, ".count"}, count, q.size());
        if (q.size() != 0) check({tag, ".data"}, data, q[0]);
        rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
        if (q.size() != 0) void'(q.pop_front());
    endtask

    task automatic check_flags(input string tag);
        @(negedge clk);
        check({tag, ".frame_err"}, frame_err, m_fe);
        check({tag, ".overrun"}, overrun, m_ov);
        check({tag, ".break_det"}, break_det, m_brk);
    endtask

    task automatic drain(input string tag);
        while (q.size() != 0) read_one(tag);
        @(negedge clk);
        check({tag, ".empty_valid"}, valid, 1'b0);
        check({tag, ".empty_count"}, count, 0);
    endtask

    task automatic clear_flags();
        @(negedge clk);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        m_fe  = 1'b0;
        m_ov  = 1'b0;
        m_brk = 1'b0;
    endtask

    byte unsigned rb;
    real          rf;

    initial begin
        reset   = 1'b1;
        uart_rx = 1'b1;
        rd      = 1'b0;
        clr_err = 1'b0;
        m_fe    = 1'b0;
        m_ov    = 1'b0;
        m_brk   = 1'b0;
        repeat (3) @(negedge clk);
        check("rst.valid", valid, 1'b0);
        check("rst.count", count, 0);
        check("rst.data", data, 8'h00);
        check_flags("rst");
        reset = 1'b0;
        #(BIT_T);

        // single byte, then pop on empty must do nothing
        send_frame(8'h55, 1'b1, 1.0, 1'b0);
        read_one("t1");
        drain("t1");
        @(negedge clk);
        rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
        drain("rd_empty");

        send_frame(8'h00, 1'b1, 1.0, 1'b0);
        send_frame(8'hFF, 1'b1, 1.0, 1'b0);
        send_frame(8'hA5, 1'b1, 1.0, 1'b0);
        check_flags("b2b");
        drain("b2b");

        // quarter-bit glitch is rejected, then a real frame still decodes
        uart_rx = 1'b0;
        #(4 * DIV * CLK_T);
        uart_rx = 1'b1;
        #(2 * BIT_T);
        check("glitch.count", count, 0);
        check_flags("glitch");
        send_frame(8'h5A, 1'b1, 1.0, 1'b0);
        drain("glitch_after");

        send_frame(8'h3C, 1'b0, 1.0, 1'b0);
        check("ferr.count", count, 0);
        check_flags("ferr");
        #(2 * BIT_T);
        uart_rx = 1'b0;
        #(11 * BIT_T);
        m_fe  = 1'b1;
        m_brk = 1'b1;
        check_flags("brk");
        clear_flags();
        #(9 * BIT_T);
        check_flags("brk_once");
        uart_rx = 1'b1;
        #(2 * BIT_T);
        check_flags("brk_end");
        check("brk.count", count, 0);

        for (int i = 1; i <= 17; i++) send_frame(byte'(i), 1'b1, 1.0, 1'b0);
        check_flags("ovr");
        drain("ovr");
        clear_flags();
        check_flags("ovr_clr");

        for (int i = 1; i <= 16; i++) send_frame(byte'(i), 1'b1, 1.0, 1'b0);
        @(negedge clk);
        send_frame(8'h11, 1'b1, 1.0, 1'b1);
        check_flags("ovr_rd");
        drain("ovr_rd");

        // reset held from mid bit 4 until past the stop bit
        fork
            send_frame(8'hC3, 1'b1, 1.0, 1'b0);
            begin
                #(5.5 * BIT_T);
                reset = 1'b1;
            end
        join
        q.delete();
        @(negedge clk);
        check("rstmid.valid", valid, 1'b0);
        check("rstmid.count", count, 0);
        reset = 1'b0;
        #(BIT_T);
        send_frame(8'h7E, 1'b1, 1.0, 1'b0);
        drain("rstmid_after");

        send_frame(8'hB2, 1'b1, 0.98, 1'b0);
        send_frame(8'h4D, 1'b1, 1.02, 1'b0);
        drain("baud_err");

        for (int n = 0; n < 12; n++) begin
            rb = 8'($urandom_range(0, 255));
            rf = 0.98 + 0.001 * $urandom_range(0, 40);
            #($urandom_range(0, 2) * BIT_T);
            send_frame(rb, 1'b1, rf, 1'b0);
            if ($urandom_range(0, 1) == 1) read_one("rnd");
        end
        check_flags("rnd");
        drain("rnd");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
